sc_pointmatrix: RTL and testbench

SC_POINTMATRIX -- requirements
Module: sc_pointmatrix

---
 rtl/sc_pointmatrix_pkg.sv | 19 +
 rtl/sc_pointmatrix_if.sv | 29 ++
 rtl/sc_onehotshift.sv | 24 ++
 rtl/sc_pointmatrix.sv | 90 +++++++++
 tb/tb_sc_pointmatrix.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/sc_pointmatrix_pkg.sv
// Shared game definitions: shift-selection encodings, start column and move counter limit.
// Used by the point matrix datapath and the point control FSM.
package sc_pointmatrix_pkg;

  typedef enum logic [1:0] {
    SHIFT_HOLD    = 2'b00,
    SHIFT_LEFT    = 2'b01,
    SHIFT_RIGHT   = 2'b10,
    SHIFT_HOLDALT = 2'b11
  } shiftSel_e;

  localparam int         START_COL_DEFAULT = 4;
  localparam logic [7:0] MOVES_MAX         = 8'd255;

  function automatic logic [7:0] satInc(input logic [7:0] value);
    return (value == MOVES_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sc_pointmatrix_if.sv
// Command strobes and display/status outputs of the point matrix.
// Master drives commands and observes outputs; slave is the matrix itself.
interface sc_pointmatrix_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic                 SC_POINTMATRIX_clear_InLow;
  logic                 SC_POINTMATRIX_load0_InLow;
  logic                 SC_POINTMATRIX_load1_InLow;
  logic [1:0]           SC_POINTMATRIX_shiftselection_In;
  logic [ROWS*COLS-1:0] SC_POINTMATRIX_matrix_Out;
  logic                 SC_POINTMATRIX_bottomsidecomparator_OutLow;
  logic                 SC_POINTMATRIX_goal_Out;
  logic [7:0]           SC_POINTMATRIX_moves_Out;

  modport master (
    output SC_POINTMATRIX_clear_InLow, SC_POINTMATRIX_load0_InLow,
           SC_POINTMATRIX_load1_InLow, SC_POINTMATRIX_shiftselection_In,
    input  SC_POINTMATRIX_matrix_Out, SC_POINTMATRIX_bottomsidecomparator_OutLow,
           SC_POINTMATRIX_goal_Out, SC_POINTMATRIX_moves_Out
  );

  modport slave (
    input  SC_POINTMATRIX_clear_InLow, SC_POINTMATRIX_load0_InLow,
           SC_POINTMATRIX_load1_InLow, SC_POINTMATRIX_shiftselection_In,
    output SC_POINTMATRIX_matrix_Out, SC_POINTMATRIX_bottomsidecomparator_OutLow,
           SC_POINTMATRIX_goal_Out, SC_POINTMATRIX_moves_Out
  );
endinterface

// File: rtl/sc_onehotshift.sv
// Combinational saturating one-hot shift: LEFT moves toward the MSB, RIGHT toward bit 0.
// Zero latency; no flow control; changed flags that the vector actually moved.
module sc_onehotshift
  import sc_pointmatrix_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] colIn,
  input  logic [1:0]       shiftSel,
  output logic [WIDTH-1:0] colOut,
  output logic             changed
);

  always_comb begin
    colOut = colIn;
    case (shiftSel)
      SHIFT_LEFT:  if (!colIn[WIDTH-1]) colOut = colIn << 1;
      SHIFT_RIGHT: if (!colIn[0])       colOut = colIn >> 1;
      default:     colOut = colIn;
    endcase
    changed = (colOut != colIn);
  end

endmodule

// File: rtl/sc_pointmatrix.sv
// Single point on a ROWS x COLS matrix: row index plus one-hot column, moved by prioritised strobes.
// Commands act on the sampling edge (outputs one cycle later); no backpressure, held strobes act every cycle.
module sc_pointmatrix
  import sc_pointmatrix_pkg::*;
#(
  parameter int COLS      = 8,
  parameter int ROWS      = 8,
  parameter int START_COL = START_COL_DEFAULT
) (
  input logic              SC_POINTMATRIX_CLOCK_50,
  input logic              SC_POINTMATRIX_RESET_InLow,
  sc_pointmatrix_if.slave  pm
);

  localparam int             RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);
  localparam logic [COLS-1:0] COL_START = COLS'(1) << START_COL;

  logic [RW-1:0]   rowIdx, nextRow;
  logic [COLS-1:0] colVec, nextCol, shiftedCol;
  logic [7:0]      moves;
  logic            goalReg, goalNext;
  logic            shiftChanged, accepted, clearCmd;
  logic [ROWS*COLS-1:0] matrixComb;

  sc_onehotshift #(.WIDTH(COLS)) uShift (
    .colIn    (colVec),
    .shiftSel (pm.SC_POINTMATRIX_shiftselection_In),
    .colOut   (shiftedCol),
    .changed  (shiftChanged)
  );

  // Exactly one command per cycle: clear > load0 > load1 > shift.
  always_comb begin
    nextRow  = rowIdx;
    nextCol  = colVec;
    accepted = 1'b0;
    clearCmd = 1'b0;
    goalNext = 1'b0;
    if (!pm.SC_POINTMATRIX_clear_InLow) begin
      clearCmd = 1'b1;
      nextRow  = ROW_LAST;
      nextCol  = COL_START;
    end else if (!pm.SC_POINTMATRIX_load0_InLow) begin
      if (rowIdx != '0) begin
        nextRow  = rowIdx - RW'(1);
        accepted = 1'b1;
        goalNext = (rowIdx == RW'(1));
      end
    end else if (!pm.SC_POINTMATRIX_load1_InLow) begin
      if (rowIdx != ROW_LAST) begin
        nextRow  = rowIdx + RW'(1);
        accepted = 1'b1;
      end
    end else begin
      nextCol  = shiftedCol;
      accepted = shiftChanged;
    end
  end

  always_ff @(posedge SC_POINTMATRIX_CLOCK_50 or negedge SC_POINTMATRIX_RESET_InLow) begin
    if (!SC_POINTMATRIX_RESET_InLow) begin
      rowIdx  <= ROW_LAST;
      colVec  <= COL_START;
      moves   <= '0;
      goalReg <= 1'b0;
    end else begin
      rowIdx  <= nextRow;
      colVec  <= nextCol;
      goalReg <= goalNext;
      if (clearCmd)
        moves <= '0;
      else if (accepted)
        moves <= satInc(moves);
    end
  end

  always_comb begin
    matrixComb = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rowIdx == RW'(r)) matrixComb[r*COLS +: COLS] = colVec;
    end
  end

  assign pm.SC_POINTMATRIX_matrix_Out                  = matrixComb;
  assign pm.SC_POINTMATRIX_bottomsidecomparator_OutLow = (rowIdx != ROW_LAST);
  assign pm.SC_POINTMATRIX_goal_Out                    = goalReg;
  assign pm.SC_POINTMATRIX_moves_Out                   = moves;

endmodule

// File: tb/tb_sc_pointmatrix.sv
// Self-checking bench for sc_pointmatrix (8x8, start column 4): vector table plus directed corner sequences.
module tb_sc_pointmatrix;
  import sc_pointmatrix_pkg::*;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int START = 4;

  logic clock50    = 1'b0;
  logic resetInLow = 1'b1;
  always #5 clock50 = ~clock50;

  sc_pointmatrix_if #(.ROWS(ROWS), .COLS(COLS)) pm ();

  sc_pointmatrix #(.COLS(COLS), .ROWS(ROWS), .START_COL(START)) dut (
    .SC_POINTMATRIX_CLOCK_50    (clock50),
    .SC_POINTMATRIX_RESET_InLow (resetInLow),
    .pm                         (pm)
  );

  typedef struct {
    logic       clrN;
    logic       ld0N;
    logic       ld1N;
    logic [1:0] sh;
    int         row;
    int         col;
    int         moves;
    logic       goal;
  } vec_t;

  typedef struct {
    int   row;
    int   col;
    int   moves;
    logic goal;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic clrN, input logic ld0N, input logic ld1N,
                              input logic [1:0] sh, input int row, input int col,
                              input int moves, input logic goal);
    vec_t v;
    v.clrN = clrN; v.ld0N = ld0N; v.ld1N = ld1N; v.sh = sh;
    v.row = row; v.col = col; v.moves = moves; v.goal = goal;
    return v;
  endfunction

  function automatic logic [63:0] cellMask(input int row, input int col);
    logic [63:0] one;
    one = 64'd1;
    return one << (row * COLS + col);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic checkState(input string tag, input int row, input int col,
                            input int moves, input logic goal);
    logic expBottom;
    expBottom = (row == ROWS - 1) ? 1'b0 : 1'b1;
    chk({tag, " matrix"}, pm.SC_POINTMATRIX_matrix_Out, cellMask(row, col));
    chk({tag, " bottom"}, 64'(pm.SC_POINTMATRIX_bottomsidecomparator_OutLow), 64'(expBottom));
    chk({tag, " moves"},  64'(pm.SC_POINTMATRIX_moves_Out), 64'(moves));
    chk({tag, " goal"},   64'(pm.SC_POINTMATRIX_goal_Out), 64'(goal));
  endtask

  task automatic drive(input logic clrN, input logic ld0N, input logic ld1N, input logic [1:0] sh);
    pm.SC_POINTMATRIX_clear_InLow       = clrN;
    pm.SC_POINTMATRIX_load0_InLow       = ld0N;
    pm.SC_POINTMATRIX_load1_InLow       = ld1N;
    pm.SC_POINTMATRIX_shiftselection_In = sh;
  endtask

  task automatic popCheck(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got moves=%0d expected an entry", tag,
               pm.SC_POINTMATRIX_moves_Out);
    end else begin
      e = sb.pop_front();
      checkState(tag, e.row, e.col, e.moves, e.goal);
    end
  endtask

  // Called at a negedge; returns at the following negedge with the result checked.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    drive(v.clrN, v.ld0N, v.ld1N, v.sh);
    e.row = v.row; e.col = v.col; e.moves = v.moves; e.goal = v.goal;
    sb.push_back(e);
    @(posedge clock50);
    @(negedge clock50);
    popCheck(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int expMoves;
    // Moves                clr   ld0   ld1   sh     row col mv goal
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 6, 4, 1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 5, 4, 2, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 4, 4, 3, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 3, 4, 4, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 2, 4, 5, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1, 4, 6, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 0, 4, 7, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 0, 4, 7, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b01, 0, 5, 8, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b01, 0, 6, 9, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b01, 0, 7, 10, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b01, 0, 7, 10, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b10, 0, 6, 11, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b11, 0, 6, 11, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b00, 0, 6, 11, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 1, 6, 12, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 2'b00, 7, 4, 0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 7, 4, 0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 6, 4, 1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 7, 4, 2, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 6, 4, 3, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 2'b01, 7, 4, 4, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b10, 7, 3, 5, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b10, 7, 2, 6, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b10, 7, 1, 7, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b10, 7, 0, 8, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b10, 7, 0, 8, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 2'b00, 7, 0, 8, 1'b0));

    // Reset: asynchronous, visible before any clock edge
    drive(1'b1, 1'b1, 1'b1, 2'b00);
    #2 resetInLow = 1'b0;
    #1 checkState("reset", 7, START, 0, 1'b0);
    @(negedge clock50);
    @(negedge clock50);
    resetInLow = 1'b1;
    @(posedge clock50);
    @(negedge clock50);
    checkState("release", 7, START, 0, 1'b0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // Move counter saturation with alternating held shifts
    step(mk(1'b0, 1'b1, 1'b1, 2'b00, 7, 4, 0, 1'b0), "satclear");
    for (int i = 0; i < 262; i++) begin
      expMoves = (i + 1 > 255) ? 255 : i + 1;
      step(mk(1'b1, 1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 7,
              (i % 2 == 0) ? 5 : 4, expMoves, 1'b0), $sformatf("sat%0d", i));
    end

    // Reset during a held right shift
    step(mk(1'b0, 1'b1, 1'b1, 2'b00, 7, 4, 0, 1'b0), "rstclear");
    drive(1'b1, 1'b1, 1'b1, 2'b10);
    @(posedge clock50);
    #1 checkState("rstpre", 7, 3, 1, 1'b0);
    #1 resetInLow = 1'b0;
    #1 checkState("rstmid", 7, START, 0, 1'b0);
    @(posedge clock50);
    #1 checkState("rsthold", 7, START, 0, 1'b0);
    @(negedge clock50);
    resetInLow = 1'b1;
    @(posedge clock50);
    @(negedge clock50);
    checkState("rstresume1", 7, 3, 1, 1'b0);
    @(posedge clock50);
    @(negedge clock50);
    checkState("rstresume2", 7, 2, 2, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
